// File: rtl/chan_sel_mux_reg.sv
// chan_sel_mux_reg: registered N-input channel selector.
// A select index is accepted under a valid/ready handshake. The chosen channel is
// captured into an output register and held until the consumer takes it.
// Optional feature macro: CHAN_SEL_AUTOSCAN_EN adds a scan_en input. When scan_en is
// high, an internal round-robin counter drives the select instead of sel/sel_valid.
module chan_sel_mux_reg #(
    parameter int unsigned NCH = 16,
    parameter int unsigned DW  = 2,
    parameter int unsigned SW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] in_bus,
    input  logic [SW-1:0]     sel,
    input  logic              sel_valid,
    output logic              sel_ready,
`ifdef CHAN_SEL_AUTOSCAN_EN
    input  logic              scan_en,
`endif
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel_err,
    output logic [SW-1:0]     cur_ch
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    // Effective select request after the optional scan override.
    logic [SW-1:0]   req_sel;
    logic            req_valid;
    logic            req_ext;
    logic            accept;
    logic            sel_ok;
    logic [DW-1:0]   chan_data;

`ifdef CHAN_SEL_AUTOSCAN_EN
    logic [SW-1:0]   scan_q, scan_d;

    assign req_sel   = scan_en ? scan_q : sel;
    assign req_valid = scan_en | sel_valid;
    assign req_ext   = ~scan_en;

    // Scan counter advances on each accepted transfer while in scan mode, wrapping at NCH-1.
    always_comb begin
        scan_d = scan_q;
        if (accept && scan_en) begin
            if (32'(scan_q) == NCH - 1) begin
                scan_d = '0;
            end else begin
                scan_d = scan_q + SW'(1);
            end
        end
    end

    // Scan counter register; it keeps its value while scan mode is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end
`else
    assign req_sel   = sel;
    assign req_valid = sel_valid;
    assign req_ext   = 1'b1;
`endif

    // The scan counter never exceeds NCH-1, so an out-of-range request is always external.
    assign sel_ok = (32'(req_sel) < NCH);

    // Channel mux; only consulted when sel_ok, so out-of-range indices just yield zero.
    always_comb begin
        chan_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(req_sel) == k) begin
                chan_data = in_bus[k*DW +: DW];
            end
        end
    end

    // Ready is unconditional when idle; while holding, a new select rides on the consumer's take.
    always_comb begin
        sel_ready = 1'b1;
        unique case (state_q)
            StIdle:  sel_ready = 1'b1;
            StHold:  sel_ready = out_ready;
            default: sel_ready = 1'b1;
        endcase
    end

    assign accept = sel_ready & req_valid;

    // Next-state logic: load on a valid accept, flag an invalid accept, drain on consumption.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (sel_ok) begin
                        data_d  = chan_data;
                        ch_d    = req_sel;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end else begin
                        err_d   = req_ext;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (req_valid && sel_ok) begin
                        data_d  = chan_data;
                        ch_d    = req_sel;
                        valid_d = 1'b1;
                    end else begin
                        err_d   = req_valid & req_ext;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign cur_ch    = ch_q;

endmodule

// File: tb/tb_chan_sel_mux_reg.sv
// Directed testbench for chan_sel_mux_reg.
// dut_a: NCH=16 (main checks); dut_b: NCH=12 (out-of-range selects);
// dut_c: NCH=4 scan instance, only when CHAN_SEL_AUTOSCAN_EN is defined.
module tb_chan_sel_mux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_bus;
    logic [3:0]  sel;
    logic        sel_valid;
    logic        out_ready;
`ifdef CHAN_SEL_AUTOSCAN_EN
    logic        scan_en;
`endif

    logic        a_sel_ready, a_out_valid, a_sel_err;
    logic [1:0]  a_out_data;
    logic [3:0]  a_cur_ch;
    logic        b_sel_ready, b_out_valid, b_sel_err;
    logic [1:0]  b_out_data;
    logic [3:0]  b_cur_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chan_sel_mux_reg #(.NCH(16), .DW(2), .SW(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (a_sel_ready),
`ifdef CHAN_SEL_AUTOSCAN_EN
        .scan_en   (scan_en),
`endif
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .sel_err   (a_sel_err),
        .cur_ch    (a_cur_ch)
    );

    chan_sel_mux_reg #(.NCH(12), .DW(2), .SW(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus[23:0]),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (b_sel_ready),
`ifdef CHAN_SEL_AUTOSCAN_EN
        .scan_en   (1'b0),
`endif
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .sel_err   (b_sel_err),
        .cur_ch    (b_cur_ch)
    );

`ifdef CHAN_SEL_AUTOSCAN_EN
    logic        c_sel_ready, c_out_valid, c_sel_err;
    logic [1:0]  c_out_data;
    logic [1:0]  c_cur_ch;

    chan_sel_mux_reg #(.NCH(4), .DW(2), .SW(2)) dut_c (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus[7:0]),
        .sel       (sel[1:0]),
        .sel_valid (sel_valid),
        .sel_ready (c_sel_ready),
        .scan_en   (scan_en),
        .out_data  (c_out_data),
        .out_valid (c_out_valid),
        .out_ready (out_ready),
        .sel_err   (c_sel_err),
        .cur_ch    (c_cur_ch)
    );
`endif

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = '0; sel_valid = 1'b0; out_ready = 1'b0;
`ifdef CHAN_SEL_AUTOSCAN_EN
        scan_en = 1'b0;
`endif
        for (int k = 0; k < 16; k++) in_bus[k*2 +: 2] = 2'(k % 4);
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", a_out_valid); end
        checks++; if (a_sel_ready !== 1'b1) begin errors++; $display("FAIL reset_sel_ready got %0d want 1", a_sel_ready); end
        checks++; if (a_out_data !== 2'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", a_out_data); end
        checks++; if (a_cur_ch !== 4'd0) begin errors++; $display("FAIL reset_cur_ch got %0d want 0", a_cur_ch); end
        checks++; if (a_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %0d want 0", a_sel_err); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1; sel = 4'd5; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d want 1", a_out_valid); end
        checks++; if (a_out_data !== 2'd1) begin errors++; $display("FAIL basic_data got %0d want 1", a_out_data); end
        checks++; if (a_cur_ch !== 4'd5) begin errors++; $display("FAIL basic_cur_ch got %0d want 5", a_cur_ch); end
        checks++; if (a_sel_err !== 1'b0) begin errors++; $display("FAIL basic_sel_err got %0d want 0", a_sel_err); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got %0d want 0", a_out_valid); end
        checks++; if (a_cur_ch !== 4'd5) begin errors++; $display("FAIL basic_drain_cur_ch got %0d want 5", a_cur_ch); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; sel = 4'd9; sel_valid = 1'b1;
        step();
        out_ready = 1'b0; sel = 4'd3; sel_valid = 1'b1;
        in_bus[19:18] = 2'b11;  // disturb channel 9 while held
        #1;
        checks++; if (a_sel_ready !== 1'b0) begin errors++; $display("FAIL bp_sel_ready got %0d want 0", a_sel_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (a_out_data !== 2'd1) begin errors++; $display("FAIL bp_hold_data[%0d] got %0d want 1", i, a_out_data); end
            checks++; if (a_cur_ch !== 4'd9) begin errors++; $display("FAIL bp_hold_cur_ch[%0d] got %0d want 9", i, a_cur_ch); end
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %0d want 1", i, a_out_valid); end
        end
        in_bus[19:18] = 2'b01;
        out_ready = 1'b1;
        #1;
        checks++; if (a_sel_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0d want 1", a_sel_ready); end
        step();
        sel_valid = 1'b0;
        checks++; if (a_out_data !== 2'd3) begin errors++; $display("FAIL bp_new_data got %0d want 3", a_out_data); end
        checks++; if (a_cur_ch !== 4'd3) begin errors++; $display("FAIL bp_new_cur_ch got %0d want 3", a_cur_ch); end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_new_valid got %0d want 1", a_out_valid); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %0d want 0", a_out_valid); end
    endtask

    task automatic test_invalid();
        // dut_b (NCH=12) last held channel 3
        out_ready = 1'b1; sel = 4'd13; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        checks++; if (b_sel_err !== 1'b1) begin errors++; $display("FAIL inv_idle_err got %0d want 1", b_sel_err); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL inv_idle_valid got %0d want 0", b_out_valid); end
        checks++; if (b_cur_ch !== 4'd3) begin errors++; $display("FAIL inv_idle_cur_ch got %0d want 3", b_cur_ch); end
        checks++; if (b_out_data !== 2'd3) begin errors++; $display("FAIL inv_idle_data got %0d want 3", b_out_data); end
        step();
        checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL inv_err_pulse got %0d want 0", b_sel_err); end
        // last valid index, then first invalid index from HOLD
        sel = 4'd11; sel_valid = 1'b1;
        step();
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL inv_edge11_valid got %0d want 1", b_out_valid); end
        checks++; if (b_cur_ch !== 4'd11) begin errors++; $display("FAIL inv_edge11_cur_ch got %0d want 11", b_cur_ch); end
        checks++; if (b_out_data !== 2'd3) begin errors++; $display("FAIL inv_edge11_data got %0d want 3", b_out_data); end
        checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL inv_edge11_err got %0d want 0", b_sel_err); end
        sel = 4'd12;
        step();
        sel_valid = 1'b0;
        checks++; if (b_sel_err !== 1'b1) begin errors++; $display("FAIL inv_hold12_err got %0d want 1", b_sel_err); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL inv_hold12_valid got %0d want 0", b_out_valid); end
        checks++; if (b_cur_ch !== 4'd11) begin errors++; $display("FAIL inv_hold12_cur_ch got %0d want 11", b_cur_ch); end
        checks++; if (a_cur_ch !== 4'd12) begin errors++; $display("FAIL inv_a12_cur_ch got %0d want 12", a_cur_ch); end
        checks++; if (a_out_data !== 2'd0) begin errors++; $display("FAIL inv_a12_data got %0d want 0", a_out_data); end
        step();
        checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL inv_hold_pulse got %0d want 0", b_sel_err); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL inv_a_drain got %0d want 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i); sel_valid = 1'b1;
            step();
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0d want 1", i, a_out_valid); end
            checks++; if (a_cur_ch !== 4'(i)) begin errors++; $display("FAIL b2b_cur_ch[%0d] got %0d want %0d", i, a_cur_ch, i); end
            checks++; if (a_out_data !== 2'(i % 4)) begin errors++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, a_out_data, i % 4); end
            checks++; if (a_sel_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0d want 1", i, a_sel_ready); end
        end
        sel_valid = 1'b0;
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0d want 0", a_out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; sel = 4'd7; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0; out_ready = 1'b0;
        checks++; if (a_out_data !== 2'd3) begin errors++; $display("FAIL rmid_pre_data got %0d want 3", a_out_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0d want 0", a_out_valid); end
        checks++; if (a_out_data !== 2'd0) begin errors++; $display("FAIL rmid_data got %0d want 0", a_out_data); end
        checks++; if (a_cur_ch !== 4'd0) begin errors++; $display("FAIL rmid_cur_ch got %0d want 0", a_cur_ch); end
        checks++; if (a_sel_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0d want 1", a_sel_ready); end
        step();
        rst = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %0d want 0", a_out_valid); end
    endtask

`ifdef CHAN_SEL_AUTOSCAN_EN
    task automatic test_autoscan();
        out_ready = 1'b1; sel_valid = 1'b0; sel = 4'd15; scan_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (c_cur_ch !== 2'(i % 4)) begin errors++; $display("FAIL scan_cur_ch[%0d] got %0d want %0d", i, c_cur_ch, i % 4); end
            checks++; if (c_out_data !== 2'(i % 4)) begin errors++; $display("FAIL scan_data[%0d] got %0d want %0d", i, c_out_data, i % 4); end
            checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL scan_valid[%0d] got %0d want 1", i, c_out_valid); end
            checks++; if (c_sel_err !== 1'b0) begin errors++; $display("FAIL scan_err[%0d] got %0d want 0", i, c_sel_err); end
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL scan_rst_valid got %0d want 0", c_out_valid); end
        step();
        rst = 1'b0;
        step();
        checks++; if (c_cur_ch !== 2'd0) begin errors++; $display("FAIL scan_restart0 got %0d want 0", c_cur_ch); end
        step();
        checks++; if (c_cur_ch !== 2'd1) begin errors++; $display("FAIL scan_restart1 got %0d want 1", c_cur_ch); end
        scan_en = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
`ifdef CHAN_SEL_AUTOSCAN_EN
        test_autoscan();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
